// File: rtl/aes_128_sched.sv
// Issue scheduler for a fully pipelined AES-128 core: round-robin arbitration, tag delay line, credit-guarded output FIFO.
// Optional statistics counters are built only when AES_SCHED_STATS_EN is defined.
module aes_128_sched #(
  parameter int CORE_LAT   = 21,
  parameter int FIFO_DEPTH = 32,
  parameter int ID_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][127:0]    req_state,
  input  logic [1:0][127:0]    req_key,
  input  logic [1:0][ID_W-1:0] req_id,
  output logic [127:0]         core_state,
  output logic [127:0]         core_key,
  input  logic [127:0]         core_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic [ID_W-1:0]      out_id,
  output logic                 out_src,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 busy,
  output logic [31:0]          stat_issued,
  output logic [31:0]          stat_stall
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 128 + ID_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] credits_reg, credits_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic             last_reg;
  logic [1:0]       grant;
  logic             issue_ok, xfer, sel;
  logic             push, pop, inflight, drained;

  logic [CORE_LAT-1:0] tag_vld;
  logic [CORE_LAT-1:0] tag_src;
  logic [ID_W-1:0]     tag_id [CORE_LAT];
  logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];

  // Arbitration: on a tie the requester not granted last wins.
  always_comb begin
    issue_ok = !rst && (state_reg == ST_RUN) && !flush && (credits_reg != '0);
    grant    = req_valid;
    if (req_valid == 2'b11) begin
      grant = last_reg ? 2'b01 : 2'b10;
    end
    req_ready  = issue_ok ? grant : 2'b00;
    xfer       = |req_ready;
    sel        = req_ready[1];
    core_state = xfer ? req_state[sel] : 128'h0;
    core_key   = xfer ? req_key[sel]   : 128'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg <= 1'b1;
    end else if (xfer) begin
      last_reg <= sel;
    end
  end

  // Tag delay line; the last stage lines up with core_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_src <= '0;
      for (int i = 0; i < CORE_LAT; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      for (int i = CORE_LAT - 1; i > 0; i--) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_src[i] <= tag_src[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      tag_vld[0] <= xfer;
      tag_src[0] <= sel;
      tag_id[0]  <= req_id[sel];
    end
  end

  assign push      = tag_vld[CORE_LAT-1];
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign inflight  = |tag_vld;
  assign drained   = !inflight && !out_valid;
  assign busy      = inflight || out_valid;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {core_out, tag_id[CORE_LAT-1], tag_src[CORE_LAT-1]};
    end
  end

  always_comb begin
    {out_data, out_id, out_src} = fifo_mem[rd_ptr_reg];
  end

  // Credits cover FIFO slots not yet claimed by in-flight blocks, so a write never meets a full FIFO.
  always_comb begin
    credits_next = credits_reg;
    count_next   = count_reg;
    case ({xfer, pop})
      2'b10:   credits_next = credits_reg - CNT_W'(1);
      2'b01:   credits_next = credits_reg + CNT_W'(1);
      default: credits_next = credits_reg;
    endcase
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_reg <= DEPTH_C;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
    end else begin
      credits_reg <= credits_next;
      count_reg   <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    flush_done = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (flush) state_next = ST_DRAIN;
      end
      default: begin
        if (drained) begin
          flush_done = 1'b1;
          state_next = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef AES_SCHED_STATS_EN
  logic [31:0] issued_reg, stall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_reg <= '0;
      stall_reg  <= '0;
    end else begin
      if (xfer && (issued_reg != 32'hFFFF_FFFF)) begin
        issued_reg <= issued_reg + 32'd1;
      end
      if ((req_valid != 2'b00) && (req_ready == 2'b00) && (stall_reg != 32'hFFFF_FFFF)) begin
        stall_reg <= stall_reg + 32'd1;
      end
    end
  end

  assign stat_issued = issued_reg;
  assign stat_stall  = stall_reg;
`else
  assign stat_issued = 32'h0;
  assign stat_stall  = 32'h0;
`endif

endmodule

// File: tb/tb_aes_128_sched.sv
// Self-checking bench for aes_128_sched: a stand-in core pipeline, a scoreboard queue and one task per scenario.
module tb_aes_128_sched;
  localparam int CORE_LAT   = 21;
  localparam int FIFO_DEPTH = 32;
  localparam int ID_W       = 4;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][127:0]    req_state;
  logic [1:0][127:0]    req_key;
  logic [1:0][ID_W-1:0] req_id;
  logic [127:0]         core_state, core_key, core_out;
  logic                 out_valid, out_ready;
  logic [127:0]         out_data;
  logic [ID_W-1:0]      out_id;
  logic                 out_src;
  logic                 flush, flush_done, busy;
  logic [31:0]          stat_issued, stat_stall;

  always #5 clk = ~clk;

  aes_128_sched #(.CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state),
    .req_key(req_key), .req_id(req_id),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_src(out_src),
    .flush(flush), .flush_done(flush_done), .busy(busy),
    .stat_issued(stat_issued), .stat_stall(stat_stall)
  );

  // Stand-in core: answers the FIPS-197 vector exactly, otherwise a cheap keyed mix.
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h3c3c_a5a5_0f0f_5a5a_c3c3_1234_8765_f00d;
  endfunction

  function automatic logic [127:0] mk_state(input int i, input int k);
    return {32'(k) ^ 32'h1357_9bdf, 32'(i), 32'(k * 3 + i), 32'hfeed_0000 + 32'(k)};
  endfunction

  function automatic logic [127:0] mk_key(input int i, input int k);
    return {4{32'h0f1e_2d3c + 32'(i * 97 + k)}};
  endfunction

  logic [127:0] core_pipe [CORE_LAT];
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(core_state, core_key);
    for (int i = 1; i < CORE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[CORE_LAT-1];

  typedef struct packed {
    logic [127:0]    data;
    logic [ID_W-1:0] id;
    logic            src;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   sent[2];
  int   tot[2];
  int   acc_cnt;

  // Scoreboard: push on every observed handshake, pop and compare on every FIFO pop.
  always @(negedge clk) begin : sb
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.data = core_fn(req_state[i], req_key[i]);
          e.id   = req_id[i];
          e.src  = 1'(i);
          exp_q.push_back(e);
          grant_log.push_back(i);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        pops++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got data %h id %0d src %0d, expected no block", out_data, out_id, out_src);
        end else begin
          e = exp_q.pop_front();
          if ({out_data, out_id, out_src} !== {e.data, e.id, e.src}) begin
            errors++;
            $display("FAIL sb_block: got data %h id %0d src %0d, expected data %h id %0d src %0d",
                     out_data, out_id, out_src, e.data, e.id, e.src);
          end else begin
            $display("pop  data %h id %0d src %0d", out_data, out_id, out_src);
          end
        end
      end
    end
  end

  task automatic drive_reqs();
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = (sent[i] < tot[i]);
      req_state[i] = mk_state(i, sent[i]);
      req_key[i]   = mk_key(i, sent[i]);
      req_id[i]    = ID_W'(sent[i]);
    end
  endtask

  // One clock: observe handshakes at negedge, then re-drive just after the active edge.
  task automatic cycle_step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        sent[i]++;
        acc_cnt++;
      end
    end
    @(posedge clk);
    #1;
    drive_reqs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    sent = '{0, 0};
    tot = '{0, 0};
    drive_reqs();
    exp_q.delete();
    grant_log.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    sent = '{0, 0};
    tot = '{1, 1};
    drive_reqs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b, expected 00", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b, expected 0", flush_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (stat_issued !== 32'd0) begin errors++; $display("FAIL reset_stat_issued: got %0d, expected 0", stat_issued); end
    checks++; if (stat_stall !== 32'd0) begin errors++; $display("FAIL reset_stat_stall: got %0d, expected 0", stat_stall); end
    $display("reset ready %b out_valid %b busy %b", req_ready, out_valid, busy);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tot = '{0, 0};
    drive_reqs();
  endtask

  task automatic test_fips();
    int lat;
    out_ready = 1'b1;
    req_valid = 2'b01;
    req_state[0] = FIPS_PT;
    req_key[0] = FIPS_KEY;
    req_id[0] = ID_W'(3);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fips_grant: got %b, expected 01", req_ready); end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    lat = -1;
    for (int k = 0; k <= CORE_LAT + 5 && lat < 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        checks++; if (out_data !== FIPS_CT) begin errors++; $display("FAIL fips_data: got %h, expected %h", out_data, FIPS_CT); end
        checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL fips_src: got %0d, expected 0", out_src); end
        checks++; if (out_id !== ID_W'(3)) begin errors++; $display("FAIL fips_id: got %0d, expected 3", out_id); end
      end
    end
    checks++; if (lat != CORE_LAT) begin errors++; $display("FAIL fips_latency: got %0d, expected %0d", lat, CORE_LAT); end
    $display("fips latency %0d data %h", lat, out_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int cyc, bad, first_bad;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    tot = '{16, 16};
    drive_reqs();
    cyc = 0;
    while ((sent[0] < 16 || sent[1] < 16) && cyc < 100) begin
      cycle_step();
      cyc++;
    end
    checks++; if (cyc != 32) begin errors++; $display("FAIL b2b_cycles: got %0d, expected 32", cyc); end
    checks++; if (grant_log.size() != 32) begin errors++; $display("FAIL b2b_grants: got %0d, expected 32", grant_log.size()); end
    bad = 0;
    first_bad = -1;
    for (int j = 0; j < grant_log.size(); j++) begin
      if (grant_log[j] != (j % 2)) begin
        bad++;
        if (first_bad < 0) first_bad = j;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_order: got %0d out-of-turn grants (first at %0d), expected 0", bad, first_bad); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: got busy or pending blocks, expected idle"); end
    $display("b2b cycles %0d grants %0d", cyc, grant_log.size());
  endtask

  task automatic test_credits();
    bit ok;
    out_ready = 1'b0;
    tot[0] = sent[0] + 40;
    tot[1] = sent[1];
    acc_cnt = 0;
    drive_reqs();
    repeat (60) cycle_step();
    checks++; if (acc_cnt != FIFO_DEPTH) begin errors++; $display("FAIL credit_fill: got %0d accepts, expected %0d", acc_cnt, FIFO_DEPTH); end
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL credit_block: got ready %b, expected 00", req_ready); end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycle_step();
    out_ready = 1'b0;
    acc_cnt = 0;
    repeat (30) cycle_step();
    checks++; if (acc_cnt != 1) begin errors++; $display("FAIL credit_one_more: got %0d accepts, expected 1", acc_cnt); end
    tot[0] = sent[0];
    drive_reqs();
    out_ready = 1'b1;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL credit_drain: got busy or pending blocks, expected idle"); end
    $display("credits filled %0d then one more", FIFO_DEPTH);
  endtask

  task automatic test_flush();
    int last_pop, done_at, acc;
    bit done_seen, ok;
    out_ready = 1'b1;
    tot[0] = sent[0] + 100;
    drive_reqs();
    repeat (10) cycle_step();
    flush = 1'b1;
    acc = 0;
    last_pop = -1;
    done_at = -1;
    done_seen = 1'b0;
    for (int k = 0; k < 80 && !done_seen; k++) begin
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) begin
        sent[0]++;
        acc++;
      end
      if (out_valid && out_ready) last_pop = k;
      if (flush_done) begin
        done_seen = 1'b1;
        done_at = k;
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
      drive_reqs();
    end
    checks++; if (acc != 0) begin errors++; $display("FAIL flush_accepts: got %0d, expected 0", acc); end
    checks++; if (!done_seen || done_at != last_pop + 1) begin
      errors++; $display("FAIL flush_done_time: got cycle %0d, expected %0d", done_at, last_pop + 1);
    end
    @(negedge clk);
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_pulse: got %b, expected 0", flush_done); end
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL flush_resume: got %b, expected 1", req_ready[0]); end
    if (req_valid[0] && req_ready[0]) sent[0]++;
    @(posedge clk);
    #1;
    tot[0] = sent[0];
    drive_reqs();
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_drain: got busy or pending blocks, expected idle"); end
    $display("flush done at %0d last pop %0d", done_at, last_pop);
  endtask

  task automatic test_reset_mid();
    int stale, n;
    bit found;
    logic [127:0] got, exp_ct;
    out_ready = 1'b0;
    tot[0] = sent[0] + 3;
    drive_reqs();
    repeat (28) cycle_step();
    tot[0] = sent[0] + 5;
    drive_reqs();
    repeat (7) cycle_step();
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b, expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale++;
      @(posedge clk);
      #1;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale: got %0d stale cycles, expected 0", stale); end
    n = sent[0];
    exp_ct = core_fn(mk_state(0, n), mk_key(0, n));
    tot[0] = n + 1;
    drive_reqs();
    found = 1'b0;
    got = '0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) sent[0]++;
      if (out_valid) begin
        found = 1'b1;
        got = out_data;
      end
      @(posedge clk);
      #1;
      drive_reqs();
    end
    checks++; if (!found || got !== exp_ct) begin errors++; $display("FAIL rstmid_next: got %h, expected %h", got, exp_ct); end
    $display("reset mid-flight stale %0d next %h", stale, got);
  endtask

  task automatic test_stats();
    int cyc;
    bit ok;
    logic [31:0] exp_issued, exp_stall;
`ifdef AES_SCHED_STATS_EN
    exp_issued = 32'd100;
    exp_stall  = 32'd7;
`else
    exp_issued = 32'd0;
    exp_stall  = 32'd0;
`endif
    do_reset();
    out_ready = 1'b0;
    tot[0] = 100;
    drive_reqs();
    cyc = 0;
    while (sent[0] < FIFO_DEPTH && cyc < 60) begin
      cycle_step();
      cyc++;
    end
    repeat (7) cycle_step();
    tot[0] = sent[0];
    drive_reqs();
    out_ready = 1'b1;
    wait_idle(ok);
    tot[0] = 100;
    drive_reqs();
    cyc = 0;
    while (sent[0] < 100 && cyc < 200) begin
      cycle_step();
      cyc++;
    end
    wait_idle(ok);
    checks++; if (!ok || sent[0] != 100) begin errors++; $display("FAIL stats_run: got %0d sent idle %0d, expected 100 idle 1", sent[0], ok); end
    checks++; if (stat_issued !== exp_issued) begin errors++; $display("FAIL stats_issued: got %0d, expected %0d", stat_issued, exp_issued); end
    checks++; if (stat_stall !== exp_stall) begin errors++; $display("FAIL stats_stall: got %0d, expected %0d", stat_stall, exp_stall); end
    $display("stats issued %0d stall %0d", stat_issued, stat_stall);
  endtask

  initial begin
    test_reset();
    test_fips();
    test_back_to_back();
    test_credits();
    test_flush();
    test_reset_mid();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end
endmodule
